p12_cfg_sequencer: RTL and testbench

Configuration and run-control sequencer that sits directly upstream of the p12 tile array. It drives the array-wide scan enable, scan data, flip-flop gate, latch gate, loop-breaker and v/h/d flip-select strobes. It accepts commands over a valid/ready interface:
- LOAD: shift a bitstream into the scan chain.
- COMMIT: latch chain bits into the tiles' flip latches.
- RUN: clock the user design for N cycles.
- READ: non-destructive readback of the chain.

---
 rtl/p12_cfg_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_p12_cfg_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p12_cfg_sequencer.sv
// p12_cfg_sequencer
// Configuration and run-control sequencer for the p12 tile array.
// Commands arrive over a valid/ready interface and drive the array-wide
// scan / gate / strobe signals:
//   LOAD   (op 0) shift a byte stream into the scan chain, LSB first
//   COMMIT (op 1) one latch-gate cycle with {v,h,d} = cmd_arg[2:0]
//   RUN    (op 2) N functional cycles (latch phase then flop phase), N=0 -> 256
//   READ   (op 3) recirculating, non-destructive readback of the chain
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready/op/arg     command handshake
//   dat_valid/dat_ready/dat_data   LOAD byte stream
//   rd_valid/rd_ready/rd_data      READ byte stream
//   arr_sc_ret                     scan output of the last tile
//   arr_se, arr_sc, arr_ff_gate,
//   arr_l_gate, arr_lb,
//   arr_v, arr_h, arr_d            array control outputs
//   busy                           sequencer not idle
module p12_cfg_sequencer #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    input  logic       dat_valid,
    output logic       dat_ready,
    input  logic [7:0] dat_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    input  logic       arr_sc_ret,
    output logic       arr_se,
    output logic       arr_sc,
    output logic       arr_ff_gate,
    output logic       arr_l_gate,
    output logic       arr_lb,
    output logic       arr_v,
    output logic       arr_h,
    output logic       arr_d,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMMIT, S_RUN_L, S_RUN_F, S_READ
    } state_t;

    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;          // chain bits shifted so far
    logic [7:0]       buf_q, buf_d;          // LOAD shift buffer
    logic [3:0]       buf_cnt_q, buf_cnt_d;  // valid bits left in buf_q
    logic [8:0]       run_q, run_d;          // functional cycles remaining
    logic [2:0]       vhd_q, vhd_d;
    logic [7:0]       asm_q, asm_d;          // READ byte being assembled
    logic [2:0]       pos_q, pos_d;          // bit position within asm_q
    logic             pend_q, pend_d;        // asm_q holds a finished byte
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;

    // LOAD: bits still to be fetched = chain length minus shifted minus buffered.
    logic [CNT_W-1:0] rem_fetch;
    logic [3:0]       fetch_n;
    logic             load_shift;
    assign rem_fetch  = LEN_C - cnt_q - CNT_W'(buf_cnt_q);
    assign fetch_n    = (int'(rem_fetch) >= 8) ? 4'd8 : 4'(rem_fetch);
    assign load_shift = (state_q == S_LOAD) && (buf_cnt_q != 4'd0);

    // READ: a new bit may only be taken when a finished byte has somewhere
    // to go, either the output slot or the single pending slot.
    logic       rd_slot_free, read_shift, byte_done;
    logic [7:0] asm_new;
    assign rd_slot_free = !rd_valid_q || rd_ready;
    assign read_shift   = (state_q == S_READ) && (cnt_q != LEN_C) && (!pend_q || rd_slot_free);
    assign byte_done    = (pos_q == 3'd7) || (cnt_q == LAST_C);
    // A pending byte leaving this cycle means the new bit starts a fresh byte.
    assign asm_new      = (pend_q ? 8'h00 : asm_q) | ({7'b0, arr_sc_ret} << pos_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        buf_cnt_d  = buf_cnt_q;
        run_d      = run_q;
        vhd_d      = vhd_q;
        asm_d      = asm_q;
        pos_d      = pos_q;
        pend_d     = pend_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cnt_d     = '0;
                    buf_cnt_d = '0;
                    asm_d     = '0;
                    pos_d     = '0;
                    pend_d    = 1'b0;
                    case (cmd_op)
                        2'd0: state_d = S_LOAD;
                        2'd1: begin
                            state_d = S_COMMIT;
                            vhd_d   = cmd_arg[2:0];
                        end
                        2'd2: begin
                            state_d = S_RUN_L;
                            run_d   = (cmd_arg == 8'd0) ? 9'd256 : {1'b0, cmd_arg};
                        end
                        default: state_d = S_READ;
                    endcase
                end
            end
            S_LOAD: begin
                if (load_shift) begin
                    buf_d     = buf_q >> 1;
                    buf_cnt_d = buf_cnt_q - 4'd1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
                // A byte accepted alongside the last buffered bit's shift
                // refills the buffer without a bubble.
                if (dat_valid && dat_ready) begin
                    buf_d     = dat_data;
                    buf_cnt_d = fetch_n;
                end
                if (load_shift && (cnt_q == LAST_C)) begin
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                vhd_d   = '0;
            end
            S_RUN_L: state_d = S_RUN_F;
            S_RUN_F: begin
                if (run_q == 9'd1) begin
                    state_d = S_IDLE;
                end else begin
                    run_d   = run_q - 9'd1;
                    state_d = S_RUN_L;
                end
            end
            S_READ: begin
                if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                end
                if (pend_q && rd_slot_free) begin
                    rd_data_d  = asm_q;
                    rd_valid_d = 1'b1;
                    pend_d     = 1'b0;
                    asm_d      = '0;
                end
                if (read_shift) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    pos_d = pos_q + 3'd1;
                    if (!byte_done) begin
                        asm_d = asm_new;
                    end else if (!pend_q && rd_slot_free) begin
                        rd_data_d  = asm_new;
                        rd_valid_d = 1'b1;
                        asm_d      = '0;
                    end else begin
                        asm_d  = asm_new;
                        pend_d = 1'b1;
                    end
                end
                if ((cnt_q == LEN_C) && !pend_q && rd_valid_q && rd_ready) begin
                    state_d    = S_IDLE;
                    rd_valid_d = 1'b0;
                    rd_data_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_cnt_q  <= '0;
            run_q      <= '0;
            vhd_q      <= '0;
            asm_q      <= '0;
            pos_q      <= '0;
            pend_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            buf_cnt_q  <= buf_cnt_d;
            run_q      <= run_d;
            vhd_q      <= vhd_d;
            asm_q      <= asm_d;
            pos_q      <= pos_d;
            pend_q     <= pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Array controls are decoded from registered state; only READ's
    // gate/data follow the live handshake and return path.
    always_comb begin
        arr_se      = 1'b0;
        arr_sc      = 1'b0;
        arr_ff_gate = 1'b0;
        arr_l_gate  = 1'b0;
        arr_lb      = 1'b1;
        {arr_v, arr_h, arr_d} = 3'b000;
        case (state_q)
            S_LOAD: begin
                arr_se = 1'b1;
                if (load_shift) begin
                    arr_ff_gate = 1'b1;
                    arr_sc      = buf_q[0];
                end
            end
            S_COMMIT: begin
                arr_l_gate = 1'b1;
                {arr_v, arr_h, arr_d} = vhd_q;
            end
            S_RUN_L: begin
                arr_l_gate = 1'b1;
                arr_lb     = 1'b0;
            end
            S_RUN_F: arr_ff_gate = 1'b1;
            S_READ: begin
                arr_se = 1'b1;
                if (read_shift) begin
                    arr_ff_gate = 1'b1;
                    arr_sc      = arr_sc_ret;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign dat_ready = (state_q == S_LOAD) && (buf_cnt_q <= 4'd1) && (rem_fetch != '0);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_p12_cfg_sequencer.sv
// Randomised scoreboard bench for p12_cfg_sequencer. A simple scan-chain
// model stands in for the tile array. The stimulus side pushes expected
// per-command summaries, LOAD scan bits and READ bytes into queues; a
// negedge monitor pops and compares them as the DUT presents activity.
module tb_p12_cfg_sequencer;
    localparam int CL = 21;
    localparam int CW = 5;
    localparam int NB = (CL + 7) / 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_arg = 8'd0;
    logic       dat_valid = 1'b0;
    logic       dat_ready;
    logic [7:0] dat_data = 8'd0;
    logic       rd_valid;
    logic       rd_ready = 1'b1;
    logic [7:0] rd_data;
    logic       arr_sc_ret;
    logic       arr_se, arr_sc, arr_ff_gate, arr_l_gate, arr_lb, arr_v, arr_h, arr_d, busy;

    p12_cfg_sequencer #(.CHAIN_LEN(CL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .arr_sc_ret(arr_sc_ret), .arr_se(arr_se), .arr_sc(arr_sc),
        .arr_ff_gate(arr_ff_gate), .arr_l_gate(arr_l_gate), .arr_lb(arr_lb),
        .arr_v(arr_v), .arr_h(arr_h), .arr_d(arr_d), .busy(busy)
    );

    always #5 clk = ~clk;

    // Tile-array stand-in: a plain CL-bit scan chain.
    logic [CL-1:0] chain;
    always @(posedge clk) if (arr_se && arr_ff_gate) chain <= {chain[CL-2:0], arr_sc};
    assign arr_sc_ret = chain[CL-1];

    // rd_ready policy: 0 = always ready, 1 = random, 2 = held low.
    int rd_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rd_mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = 1'($urandom_range(0, 1));
            default: rd_ready = 1'b0;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         op;
        int         cyc;   // -1 = not checked
        int         ff;
        int         l;
        int         lb0;
        int         bytes;
        int         hs;
        logic [2:0] vhd;
    } exp_t;

    exp_t       exp_q[$];
    bit         exp_sc_q[$];
    logic [7:0] exp_rd_q[$];

    // Reference: the bit stream most recently loaded, in load order.
    bit         ref_bits[CL];
    logic [7:0] ld_bytes[NB];

    localparam logic [18:0] IDLE_VEC = {5'b00001, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1};
    logic [18:0] out_vec;
    assign out_vec = {arr_se, arr_sc, arr_ff_gate, arr_l_gate, arr_lb, arr_v, arr_h, arr_d,
                      dat_ready, rd_valid, rd_data, cmd_ready};

    // ---------------- monitor ----------------
    exp_t       cur;
    bit         active = 1'b0;
    int         k, c_ff, c_l, c_lb0, c_bytes, c_hs, c_bad;
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data;
    logic [7:0] e_rd;
    bit         e_sc;
    logic [2:0] exp3;

    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
            prev_hold = 1'b0;
            exp_q.delete();
            exp_sc_q.delete();
            exp_rd_q.delete();
        end else begin
            if (busy && !active) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                    cur = '{op: -1, cyc: -1, ff: 0, l: 0, lb0: 0, bytes: 0, hs: 0, vhd: 3'b000};
                end else begin
                    cur = exp_q.pop_front();
                end
                active = 1'b1;
                k = 0; c_ff = 0; c_l = 0; c_lb0 = 0; c_bytes = 0; c_hs = 0; c_bad = 0;
            end
            if (prev_hold) begin
                chk("rd_hold_valid", int'(rd_valid), 1);
                chk("rd_hold_data", int'(rd_data), int'(prev_data));
            end
            prev_hold = rd_valid && !rd_ready;
            prev_data = rd_data;
            if (rd_valid && rd_ready) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    e_rd = exp_rd_q.pop_front();
                    chk("rd_data", int'(rd_data), int'(e_rd));
                end
                c_hs++;
            end
            if (active && busy) begin
                if (arr_ff_gate) c_ff++;
                if (arr_l_gate) c_l++;
                if (!arr_lb) c_lb0++;
                if (dat_valid && dat_ready) c_bytes++;
                case (cur.op)
                    0: begin
                        if (!arr_se || arr_l_gate || {arr_v, arr_h, arr_d} != 3'b000) c_bad++;
                        if (arr_ff_gate) begin
                            if (exp_sc_q.size() == 0) chk("load_sc_extra", 1, 0);
                            else begin
                                e_sc = exp_sc_q.pop_front();
                                chk("load_sc", int'(arr_sc), int'(e_sc));
                            end
                        end
                    end
                    1: if ({arr_l_gate, arr_lb, arr_ff_gate, arr_se} != 4'b1100 ||
                           {arr_v, arr_h, arr_d} != cur.vhd) c_bad++;
                    2: begin
                        exp3 = (k % 2 == 0) ? 3'b100 : 3'b011;
                        if ({arr_l_gate, arr_lb, arr_ff_gate} != exp3 || arr_se ||
                            {arr_v, arr_h, arr_d} != 3'b000) c_bad++;
                    end
                    3: if (!arr_se || arr_l_gate || {arr_v, arr_h, arr_d} != 3'b000) c_bad++;
                    default: ;
                endcase
                k++;
            end
            if (!busy) begin
                chk("idle_outputs", int'(out_vec), int'(IDLE_VEC));
                if (active) begin
                    active = 1'b0;
                    $display("[TB] op %0d done: cycles %0d ff %0d l %0d lb0 %0d bytes %0d rd %0d",
                             cur.op, k, c_ff, c_l, c_lb0, c_bytes, c_hs);
                    if (cur.cyc >= 0) chk("cmd_cycles", k, cur.cyc);
                    chk("ff_cycles", c_ff, cur.ff);
                    chk("l_cycles", c_l, cur.l);
                    chk("lb0_cycles", c_lb0, cur.lb0);
                    chk("cycle_shape", c_bad, 0);
                    if (cur.op == 0) chk("load_bytes", c_bytes, cur.bytes);
                    if (cur.op == 3) chk("read_bytes", c_hs, cur.hs);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] op, input logic [7:0] arg);
        int t;
        t = 0;
        @(posedge clk); #1;
        cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        chk("cmd_accept", int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 2000) begin @(negedge clk); t++; end
        if (busy) begin
            chk("idle_timeout", 1, 0);
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
        end
    endtask

    task automatic do_load(input bit gaps);
        int t, g;
        for (int i = 0; i < CL; i++) begin
            ref_bits[i] = ld_bytes[i / 8][i % 8];
            exp_sc_q.push_back(ref_bits[i]);
        end
        exp_q.push_back('{op: 0, cyc: gaps ? -1 : CL + 1, ff: CL, l: 0, lb0: 0,
                          bytes: NB, hs: 0, vhd: 3'b000});
        issue(2'd0, 8'($urandom));
        for (int b = 0; b < NB; b++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                dat_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            dat_valid = 1'b1;
            dat_data = ld_bytes[b];
            t = 0;
            @(negedge clk);
            while (!dat_ready && t < 100) begin @(negedge clk); t++; end
            chk("dat_accept", int'(dat_ready), 1);
            @(posedge clk); #1;
        end
        dat_valid = 1'b0;
        wait_idle();
    endtask

    function automatic logic [7:0] ref_byte(input int j);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) if (8 * j + i < CL) b[i] = ref_bits[8 * j + i];
        return b;
    endfunction

    task automatic push_read(input int cyc);
        for (int j = 0; j < NB; j++) exp_rd_q.push_back(ref_byte(j));
        exp_q.push_back('{op: 3, cyc: cyc, ff: CL, l: 0, lb0: 0, bytes: 0, hs: NB, vhd: 3'b000});
    endtask

    task automatic do_read(input int mode);
        rd_mode = mode;
        push_read(mode == 0 ? CL + 1 : -1);
        issue(2'd3, 8'($urandom));
        wait_idle();
        rd_mode = 0;
    endtask

    task automatic do_commit(input logic [2:0] mask);
        exp_q.push_back('{op: 1, cyc: 1, ff: 0, l: 1, lb0: 0, bytes: 0, hs: 0, vhd: mask});
        issue(2'd1, {5'($urandom), mask});
        wait_idle();
    endtask

    task automatic do_run(input logic [7:0] n);
        int nn;
        nn = (n == 8'd0) ? 256 : int'(n);
        exp_q.push_back('{op: 2, cyc: 2 * nn, ff: nn, l: nn, lb0: nn, bytes: 0, hs: 0, vhd: 3'b000});
        issue(2'd2, n);
        wait_idle();
    endtask

    int         t0, nsh, unstable, op;
    logic [7:0] d0;

    initial begin
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", int'(out_vec), int'(IDLE_VEC));
        chk("reset_busy", int'(busy), 0);

        // Directed: counting pattern, no gaps, then two reads.
        ld_bytes[0] = 8'h01; ld_bytes[1] = 8'h02; ld_bytes[2] = 8'h03;
        do_load(1'b0);
        do_read(0);
        do_read(0);

        // All ones: final byte padded with zeros.
        ld_bytes[0] = 8'hFF; ld_bytes[1] = 8'hFF; ld_bytes[2] = 8'hFF;
        do_load(1'b0);
        do_read(0);

        do_commit(3'b101);
        do_run(8'd0);
        do_run(8'd3);

        // Randomised mix.
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    for (int b = 0; b < NB; b++) ld_bytes[b] = 8'($urandom);
                    do_load(1'($urandom_range(0, 1)));
                end
                1: do_commit(3'($urandom));
                2: do_run(8'($urandom_range(1, 20)));
                default: do_read($urandom_range(0, 1));
            endcase
        end

        // Stall: consumer not ready after first byte.
        for (int b = 0; b < NB; b++) ld_bytes[b] = 8'($urandom);
        do_load(1'b1);
        rd_mode = 2;
        push_read(-1);
        issue(2'd3, 8'h00);
        t0 = 0;
        while (!rd_valid && t0 < 100) begin @(negedge clk); t0++; end
        chk("stall_first_valid", int'(rd_valid), 1);
        d0 = rd_data;
        nsh = int'(arr_ff_gate);
        unstable = 0;
        repeat (20) begin
            @(negedge clk);
            nsh += int'(arr_ff_gate);
            if (rd_data !== d0 || !rd_valid) unstable++;
        end
        chk("stall_shifts", nsh, (CL - 8 >= 8) ? 8 : CL - 8);
        chk("stall_hold", unstable, 0);
        rd_mode = 0;
        wait_idle();

        // Reset in the middle of a READ.
        push_read(-1);
        issue(2'd3, 8'h00);
        repeat (5) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midread_reset_outputs", int'(out_vec), int'(IDLE_VEC));
        chk("midread_reset_busy", int'(busy), 0);

        // Chain contents now undefined: reload and read back.
        for (int b = 0; b < NB; b++) ld_bytes[b] = 8'($urandom);
        do_load(1'b0);
        do_read(1);

        repeat (3) @(negedge clk);
        chk("exp_cmds_left", exp_q.size(), 0);
        chk("exp_rd_left", exp_rd_q.size(), 0);
        chk("exp_sc_left", exp_sc_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
